ib_flow_controller: RTL and testbench
=====================================

# ib_flow_controller

Sequencing controller for the trace input buffer. It owns the circular-queue bookkeeping: head/tail pointers, occupancy, per-entry EOF flags, and overflow accounting. It drives the write/read strobes and addresses of the buffer's dual-port RAM. Reads are released to the downstream filter/reduction units in bursts of BURST vectors, except when a frame end is pending, when the controller drains immediately.

## Interface
- IB_DEPTH, default 4: buffer entries; power of two, ≥2. AW = $clog2(IB_DEPTH).
- BURST, default 2: minimum occupancy before reads start when no EOF is pending; 1..IB_DEPTH.
- RAM_LATENCY, default 1: read latency of the buffer RAM in cycles; ≥1.
- CNT_WIDTH, default 16: width of the drop counter.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  trace vector present this cycle; the source cannot stall.
- eof_in  in  1  the vector ending a frame; qualified by valid_in.
- ready_in  in  1  downstream accepts a vector RAM_LATENCY cycles from now.
- wr_en  out  1  RAM port-A write strobe (combinational).
- wr_addr  out  AW  RAM write address, equal to head.
- rd_en  out  1  RAM port-B read strobe (combinational).
- rd_addr  out  AW  RAM read address, equal to tail.
- valid_out  out  1  RAM read data valid this cycle.
- eof_out  out  1  EOF flag of the entry on the RAM output, aligned with valid_out.
- occupancy  out  AW+1  stored entries (registered).
- full  out  1  occupancy == IB_DEPTH.
- empty  out  1  occupancy == 0.
- drop_count  out  CNT_WIDTH  vectors lost to overflow; saturates at all-ones.
- overflow  out  1  sticky; set on the first drop.

## Operation
Registers:
- head, tail (AW bits, wrap naturally).
- occupancy (AW+1 bits).
- eof_flag[IB_DEPTH].
- eof_pending (AW+1 bits): count of stored entries with EOF set.
- valid/eof delay lines, RAM_LATENCY stages.
- drop_count, overflow.

Read decision:
- rd_en = ready_in & !empty & (eof_pending != 0 | occupancy >= BURST).

Write decision:
- accept = valid_in & (!full | rd_en), i.e. a full buffer accepts a write in the same cycle as a read.
- wr_en = accept.

Write update (accept): eof_flag[head] <= eof_in; head++; if eof_in, eof_pending++.

Read update (rd_en): tail++; if eof_flag[tail], eof_pending--.

occupancy <= occupancy + accept - rd_en.

Drop (valid_in & !accept):
- drop_count++ (saturating); overflow <= 1.
- If eof_in is set on the dropped vector, set eof_flag[head-1] and increment eof_pending, unless that flag is already set. The frame boundary is preserved on the newest stored entry. The buffer is necessarily full, so that entry exists.

Derived states (eof_pending, occupancy):
- IDLE: empty.
- FILL: non-empty, eof_pending == 0; reads gated by BURST.
- DRAIN: eof_pending != 0; reads whenever ready_in.

State transitions:
- DRAIN → FILL when the last EOF entry is read with entries remaining.
- DRAIN → IDLE when that read empties the buffer.
- Writes continue in every state.

Outputs:
- valid_out and eof_out are rd_en and eof_flag[tail], delayed by RAM_LATENCY registers.

## Timing
- Reset (rst_n low, asynchronous): head = tail = 0, occupancy = 0, eof_flag = 0, eof_pending = 0, delay lines = 0, drop_count = 0, overflow = 0. Resulting outputs: empty = 1, full = 0, valid_out = 0, eof_out = 0, wr_en = rd_en = 0 (no state to drive them).
- Reset mid-operation discards all stored entries and pending outputs. In-flight valid_out is cleared immediately.
- Write: a vector on valid_in in cycle t is written at edge t. It is first readable at cycle t+1.
- Read: rd_en in cycle t gives valid_out/eof_out at cycle t+RAM_LATENCY.
- Latency from valid_in to valid_out is at least 1+RAM_LATENCY cycles (BURST = 1, ready_in high).
- Simultaneous read and write at full: occupancy stays IB_DEPTH and nothing is dropped.
- Simultaneous read and write at empty is impossible; rd_en requires !empty.
- Throughput: one write and one read per cycle.
- Pointer wrap: IB_DEPTH-1 → 0, with no bubble.

## Test plan
- Reset, then 1 vector with BURST=2 and ready_in=1 → no rd_en, occupancy=1. A 2nd vector → rd_en next cycle at rd_addr=0; valid_out one cycle later (RAM_LATENCY=1).
- Vector with eof_in=1 alone, BURST=2, ready_in=1 → rd_en the following cycle. valid_out=eof_out=1 at +2. End state IDLE with eof_pending=0.
- ready_in=0, 6 consecutive vectors, IB_DEPTH=4 → full=1, drop_count=2, overflow=1. wr_addr sequence 0,1,2,3 then wr_en=0.
- Full buffer, ready_in=1, valid_in held high for 8 cycles → no drops. occupancy stays 4; addresses wrap 3→0.
- Full buffer with ready_in=0, then a dropped vector with eof_in=1 → eof_flag[3] set and state becomes DRAIN. Raising ready_in produces 4 reads; the 4th has eof_out=1.
- Assert rst_n=0 mid-stream with valid_out high → valid_out=0, empty=1 and drop_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ib_flow_controller.sv
// ib_flow_controller: circular-queue bookkeeping for the trace input buffer.
// Tracks head/tail, occupancy, per-entry EOF flags and overflow, and drives
// the dual-port RAM strobes/addresses. Reads are released in bursts of BURST
// entries unless a frame end is stored, in which case the buffer drains.
//
// Derived state (no explicit state register; it follows occupancy/eof_pending)
//   state | meaning
//   IDLE  | occupancy == 0
//   FILL  | occupancy != 0, eof_pending == 0; reads wait for BURST entries
//   DRAIN | eof_pending != 0; reads whenever ready_in
module ib_flow_controller #(
  parameter int IB_DEPTH    = 4,
  parameter int BURST       = 2,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16,
  localparam int AW         = $clog2(IB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 eof_in,
  input  logic                 ready_in,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  output logic                 valid_out,
  output logic                 eof_out,
  output logic [AW:0]          occupancy,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 overflow
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(IB_DEPTH);
  localparam logic [AW:0] BURST_V = (AW+1)'(BURST);

  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [AW-1:0]          head_prev;
  logic [IB_DEPTH-1:0]    eof_flag;
  logic [AW:0]            eof_pending;
  logic [RAM_LATENCY-1:0] vld_pipe;
  logic [RAM_LATENCY-1:0] eof_pipe;
  logic                   accept;
  logic                   drop;
  logic                   eof_up;
  logic                   eof_down;

  // Read/write decisions; a full buffer still accepts when a read frees a slot.
  always_comb begin
    empty     = (occupancy == '0);
    full      = (occupancy == DEPTH_V);
    rd_en     = ready_in & ~empty & ((eof_pending != '0) | (occupancy >= BURST_V));
    accept    = valid_in & (~full | rd_en);
    drop      = valid_in & ~accept;
    wr_en     = accept;
    wr_addr   = head;
    rd_addr   = tail;
    head_prev = head - AW'(1);
    // A dropped EOF is folded onto the newest stored entry (always present when full).
    eof_up    = (accept & eof_in) | (drop & eof_in & ~eof_flag[head_prev]);
    eof_down  = rd_en & eof_flag[tail];
    valid_out = vld_pipe[RAM_LATENCY-1];
    eof_out   = eof_pipe[RAM_LATENCY-1];
  end

  // Pointers and per-entry EOF flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      eof_flag <= '0;
    end else begin
      if (accept) begin
        eof_flag[head] <= eof_in;
        head           <= head + AW'(1);
      end else if (drop && eof_in) begin
        eof_flag[head_prev] <= 1'b1;
      end
      if (rd_en) tail <= tail + AW'(1);
    end
  end

  // Occupancy and stored-EOF count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy   <= '0;
      eof_pending <= '0;
    end else begin
      if (accept && !rd_en)      occupancy <= occupancy + (AW+1)'(1);
      else if (rd_en && !accept) occupancy <= occupancy - (AW+1)'(1);
      if (eof_up && !eof_down)      eof_pending <= eof_pending + (AW+1)'(1);
      else if (eof_down && !eof_up) eof_pending <= eof_pending - (AW+1)'(1);
    end
  end

  // Overflow accounting; the counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  // Align read-valid and EOF with the RAM output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      eof_pipe[0] <= eof_flag[tail];
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ib_flow_controller.sv
// Bench for ib_flow_controller: directed scenarios plus random traffic,
// checked against a queue-based model of the buffer contents.
module tb_ib_flow_controller;
  localparam int DEPTH = 4;
  localparam int BURST = 2;
  localparam int AW    = 2;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic          eof_in = 1'b0;
  logic          ready_in = 1'b0;
  logic          wr_en, rd_en, valid_out, eof_out, full, empty, overflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   occupancy;
  logic [CW-1:0] drop_count;

  int total = 0;
  int bad   = 0;

  // model state
  bit q[$];
  int m_wa, m_ra, m_drops;
  bit m_ovf, m_vo, m_eo;

  ib_flow_controller #(.IB_DEPTH(DEPTH), .BURST(BURST), .RAM_LATENCY(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in), .ready_in(ready_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .valid_out(valid_out), .eof_out(eof_out), .occupancy(occupancy),
    .full(full), .empty(empty), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wa = 0; m_ra = 0; m_drops = 0;
    m_ovf = 0; m_vo = 0; m_eo = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_in = 0; eof_in = 0; ready_in = 0;
    #1;
    model_reset();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_vo", 32'(valid_out), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input bit v, input bit e, input bit r);
    int n;
    bit pend, rd, acc, front;
    @(negedge clk);
    valid_in = v; eof_in = e; ready_in = r;
    #1;
    n = q.size();
    pend = 0;
    foreach (q[i]) if (q[i]) pend = 1;
    rd  = r && (n > 0) && (pend || n >= BURST);
    acc = v && (n < DEPTH || rd);
    chk("rd_en", 32'(rd_en), 32'(rd));
    chk("wr_en", 32'(wr_en), 32'(acc));
    chk("wr_addr", 32'(wr_addr), 32'(m_wa));
    chk("rd_addr", 32'(rd_addr), 32'(m_ra));
    chk("occupancy", 32'(occupancy), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("valid_out", 32'(valid_out), 32'(m_vo));
    if (m_vo) chk("eof_out", 32'(eof_out), 32'(m_eo));
    front = (n > 0) ? q[0] : 1'b0;
    m_vo = rd;
    m_eo = front;
    if (rd) begin
      void'(q.pop_front());
      m_ra = (m_ra + 1) % DEPTH;
    end
    if (acc) begin
      q.push_back(e);
      m_wa = (m_wa + 1) % DEPTH;
    end else if (v) begin
      if (m_drops < 65535) m_drops++;
      m_ovf = 1;
      if (e) q[q.size()-1] = 1'b1;
    end
  endtask

  initial begin
    int eof_seen;
    bit got;

    // 1: BURST gating
    do_reset();
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t1_vo_after_read", 32'(valid_out), 1);

    // 2: lone EOF drains immediately
    do_reset();
    step(1, 1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t2_eof_out", 32'(eof_out), 1);
    chk("t2_idle", 32'(empty), 1);

    // 3: overflow with ready low
    do_reset();
    repeat (6) step(1, 0, 0);
    step(0, 0, 0);
    chk("t3_drops", 32'(drop_count), 2);
    chk("t3_full", 32'(full), 1);

    // 4: full buffer, simultaneous read+write, no drops
    repeat (8) step(1, 0, 1);
    step(0, 0, 0);
    chk("t4_occ", 32'(occupancy), 4);
    chk("t4_drops", 32'(drop_count), 2);

    // 5: dropped EOF folded onto newest entry
    do_reset();
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    eof_seen = 0;
    repeat (5) begin
      step(0, 0, 1);
      if (valid_out && eof_out) eof_seen++;
    end
    step(0, 0, 1);
    chk("t5_eof_count", 32'(eof_seen), 1);
    chk("t5_empty", 32'(empty), 1);

    // 6: random traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);

    // 7: asynchronous reset mid-stream with valid_out high
    do_reset();
    repeat (6) step(1, 0, 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step(1, 1, 1);
      if (valid_out) got = 1;
    end
    chk("t7_vo_seen", 32'(got), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_vo_cleared", 32'(valid_out), 0);
    chk("t7_empty", 32'(empty), 1);
    chk("t7_drops", 32'(drop_count), 0);
    #2;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
